// File: rtl/video_mnist_cnn_argmax.sv
// Per-pixel classifier behind the sparse-LUT MNIST CNN: popcounts each class's voting bundle,
// picks the arg-max class, applies a confidence threshold. 3-stage AXI4-Stream pipeline.
module video_mnist_cnn_argmax #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned CLASS_NUM     = 10,
  parameter int unsigned CHANNEL_NUM   = 7,
  parameter int unsigned S_TDATA_WIDTH = CLASS_NUM * CHANNEL_NUM,
  parameter int unsigned CLASS_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNT_WIDTH-1:0]   param_threshold,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  // Stage-2 split point: classes [0, Split) and [Split, CLASS_NUM) are reduced in parallel.
  localparam int unsigned Split = 5;

  logic cke;

  // Stage 1: per-class vote counts
  logic [COUNT_WIDTH-1:0] cnt_d [CLASS_NUM];
  logic [COUNT_WIDTH-1:0] cnt_q [CLASS_NUM];
  logic [TUSER_WIDTH-1:0] user1_q;
  logic                   last1_q, valid1_q;

  // Stage 2: partial arg-max of each half
  logic [CLASS_WIDTH-1:0] lo_idx_d, lo_idx_q, hi_idx_d, hi_idx_q;
  logic [COUNT_WIDTH-1:0] lo_cnt_d, lo_cnt_q, hi_cnt_d, hi_cnt_q;
  logic [TUSER_WIDTH-1:0] user2_q;
  logic                   last2_q, valid2_q;

  // Stage 3: final result
  logic [CLASS_WIDTH-1:0] win_idx, class_d, class_q;
  logic [COUNT_WIDTH-1:0] win_cnt, count_q;
  logic [TUSER_WIDTH-1:0] user3_q;
  logic                   last3_q, valid3_q;

  assign cke            = !valid3_q || m_axi4s_tready;
  assign s_axi4s_tready = cke;

  always_comb begin
    for (int unsigned c = 0; c < CLASS_NUM; c++) begin
      cnt_d[c] = '0;
      for (int unsigned b = 0; b < CHANNEL_NUM; b++) begin
        cnt_d[c] = cnt_d[c] + COUNT_WIDTH'(s_axi4s_tdata[c*CHANNEL_NUM + b]);
      end
    end
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    lo_idx_d = '0;
    lo_cnt_d = cnt_q[0];
    for (int unsigned c = 1; c < Split; c++) begin
      if (cnt_q[c] > lo_cnt_d) begin
        lo_cnt_d = cnt_q[c];
        lo_idx_d = CLASS_WIDTH'(c);
      end
    end
    hi_idx_d = CLASS_WIDTH'(Split);
    hi_cnt_d = cnt_q[Split];
    for (int unsigned c = Split + 1; c < CLASS_NUM; c++) begin
      if (cnt_q[c] > hi_cnt_d) begin
        hi_cnt_d = cnt_q[c];
        hi_idx_d = CLASS_WIDTH'(c);
      end
    end
  end

  always_comb begin
    win_idx = lo_idx_q;
    win_cnt = lo_cnt_q;
    if (hi_cnt_q > lo_cnt_q) begin
      win_idx = hi_idx_q;
      win_cnt = hi_cnt_q;
    end
    class_d = (win_cnt < param_threshold) ? CLASS_WIDTH'(CLASS_NUM) : win_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CLASS_NUM; c++) cnt_q[c] <= '0;
      user1_q  <= '0;
      last1_q  <= 1'b0;
      valid1_q <= 1'b0;
      lo_idx_q <= '0;
      lo_cnt_q <= '0;
      hi_idx_q <= '0;
      hi_cnt_q <= '0;
      user2_q  <= '0;
      last2_q  <= 1'b0;
      valid2_q <= 1'b0;
      class_q  <= '0;
      count_q  <= '0;
      user3_q  <= '0;
      last3_q  <= 1'b0;
      valid3_q <= 1'b0;
    end else if (cke) begin
      cnt_q    <= cnt_d;
      user1_q  <= s_axi4s_tuser;
      last1_q  <= s_axi4s_tlast;
      valid1_q <= s_axi4s_tvalid;
      lo_idx_q <= lo_idx_d;
      lo_cnt_q <= lo_cnt_d;
      hi_idx_q <= hi_idx_d;
      hi_cnt_q <= hi_cnt_d;
      user2_q  <= user1_q;
      last2_q  <= last1_q;
      valid2_q <= valid1_q;
      class_q  <= class_d;
      count_q  <= win_cnt;
      user3_q  <= user2_q;
      last3_q  <= last2_q;
      valid3_q <= valid2_q;
    end
  end

  assign m_axi4s_tuser  = user3_q;
  assign m_axi4s_tlast  = last3_q;
  assign m_axi4s_tclass = class_q;
  assign m_axi4s_tcount = count_q;
  assign m_axi4s_tvalid = valid3_q;

endmodule
